approx_product_accumulator: RTL
===============================

# approx_product_accumulator

- Downstream consumer of the 8x8 accuracy-controllable approximate multiplier.
- Accepts the multiplier's 16-bit unsigned product stream through a valid/ready handshake.
- Sums one vector of products into a wide accumulator and presents the finished dot-product result on an output handshake.
- Flags saturation and forced (length-limit) termination; this is the MAC back end of the approximate datapath.

## Interface

Parameters:
- ACC_W, 24, accumulator/result width; legal range 17..32.
- MAX_LEN, 16, maximum products per vector; legal range 1..255.
- CNT_W, 8, element counter width; must satisfy 2^CNT_W > MAX_LEN.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, synchronous and active-high.
- prod  input  16  unsigned product from the multiplier `out`.
- prod_valid  input  1  prod is valid this cycle.
- prod_last  input  1  final product of the vector; qualified by prod_valid.
- prod_ready  output  1  block accepts a product this cycle.
- sum  output  ACC_W  accumulated result, registered.
- count  output  CNT_W  number of products in sum, registered.
- sum_valid  output  1  result available.
- sum_ready  input  1  consumer takes the result.
- overflow  output  1  saturation occurred in this vector, registered.
- truncated  output  1  vector was ended by MAX_LEN rather than prod_last, registered.

## Operation

- Two states: ACCUM and DONE. Reset state is ACCUM.
- Accept = prod_valid & prod_ready.
- prod_ready = (state==ACCUM) & ~rst. It is combinational from the state register only; it never depends on prod_valid.

In ACCUM:
- On accept: acc <= sat(acc + zero-extended prod); cnt <= cnt+1.
- sat() clamps to 2^ACC_W-1. If clamping occurs, the sticky ovf flag is set.
- An accept with prod_last=1, or an accept that makes cnt==MAX_LEN, moves to DONE. The final product is included in the result.
- If cnt reaches MAX_LEN and prod_last=0 on that beat, trunc is set.
- If prod_last=1 on the MAX_LEN-th beat, trunc is not set.
- prod_last is ignored when prod_valid=0.

In DONE:
- sum_valid=1; sum/count/overflow/truncated show acc/cnt/ovf/trunc.
- prod_ready=0.
- Outputs stay stable until sum_valid & sum_ready.
- On sum_valid & sum_ready: acc, cnt, ovf and trunc clear to 0 and the state returns to ACCUM.
- There is no combinational path from sum_ready to prod_ready. The handshake cycle itself does not accept a product.

General:
- sum, count, overflow and truncated are driven by the accumulator registers directly. They are meaningful only when sum_valid=1.
- Arithmetic is unsigned only. No rounding.
- The multiplier's mask/accuracy mode is not seen by this block.

## Timing

- Reset values: prod_ready=0 during the rst cycle and 1 in the first cycle after it. sum=0, count=0, sum_valid=0, overflow=0, truncated=0.
- rst asserted mid-vector or in DONE discards all state at the next edge. No result is emitted for the aborted vector.
- Throughput: one product per cycle in ACCUM.
- Latency: sum_valid rises on the edge that accepts the last product, so it is visible the cycle after that accept.
- Minimum dead time between vectors: 1 cycle, the DONE handshake cycle.
- A product presented while in DONE waits; prod_valid may stay high with prod held stable.
- Back-to-back vectors with sum_ready held 1: DONE lasts exactly 1 cycle.
- Saturated beats continue to count. Once ovf is set, acc remains at max.

## Test plan

- **Single vector:** prods 100, 200, 300 with last on the third beat, sum_ready=1 → sum_valid for 1 cycle with sum=600, count=3, overflow=0, truncated=0. prod_ready low in that cycle.
- **Single-element vector:** prod=0xFFFF with last=1 → sum=65535, count=1. The next vector starts from 0.
- **Saturation:** ACC_W=17; three beats of 0xFFFF, last on the third → sum=131071, overflow=1, count=3.
- **Truncation:** MAX_LEN=4; 6 beats of value 1 with no last → first result sum=4, count=4, truncated=1. The following 2 beats plus a last beat of value 1 → second result sum=3, count=3, truncated=0.
- **Backpressure:** hold sum_ready=0 for 5 cycles after completion → sum_valid and outputs stable, prod_ready=0, the waiting prod is not consumed. Raising sum_ready → the next vector's first beat is accepted the cycle after the handshake.
- **Reset mid-vector:** assert rst after 2 of 4 beats → all outputs return to reset values. A fresh 2-beat vector of 7 and 8 then yields sum=15, count=2.

Source files
------------

// File: rtl/approx_product_accumulator_if.sv
// Product-stream and result handshake bundle for the approximate MAC back end.
interface approx_product_accumulator_if #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned CNT_W = 8
);
  logic [15:0]      prod;
  logic             prod_valid;
  logic             prod_last;
  logic             prod_ready;
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] count;
  logic             sum_valid;
  logic             sum_ready;
  logic             overflow;
  logic             truncated;

  // Producer/consumer side: feeds products, takes results.
  modport master (
    output prod, prod_valid, prod_last, sum_ready,
    input  prod_ready, sum, count, sum_valid, overflow, truncated
  );

  // Accumulator side.
  modport slave (
    input  prod, prod_valid, prod_last, sum_ready,
    output prod_ready, sum, count, sum_valid, overflow, truncated
  );
endinterface

// File: rtl/approx_product_accumulator.sv
// Saturating dot-product accumulator: sums one vector of 16-bit unsigned products,
// then holds the result until the consumer takes it.
// Legal: 17 <= ACC_W <= 32, 1 <= MAX_LEN <= 255, 2**CNT_W > MAX_LEN.
module approx_product_accumulator #(
  parameter int unsigned ACC_W   = 24,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned CNT_W   = 8
) (
  input logic                         clk,
  input logic                         rst,
  approx_product_accumulator_if.slave bus
);

  typedef enum logic {StAccum, StDone} state_e;

  state_e           r_state, w_state_next;
  logic [ACC_W-1:0] r_acc, w_acc_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             r_ovf, w_ovf_next;
  logic             r_trunc, w_trunc_next;

  logic             w_accept;
  logic [ACC_W:0]   w_sum_wide;
  logic             w_sat;
  logic [ACC_W-1:0] w_acc_add;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_hit_max;

  // Ready depends only on state and reset, never on valid or sum_ready.
  assign bus.prod_ready = (r_state == StAccum) & ~rst;
  assign w_accept       = bus.prod_valid & bus.prod_ready;

  // One extra bit catches the carry out that signals saturation.
  assign w_sum_wide = {1'b0, r_acc} + {{(ACC_W - 15){1'b0}}, bus.prod};
  assign w_sat      = w_sum_wide[ACC_W];
  assign w_acc_add  = w_sat ? {ACC_W{1'b1}} : w_sum_wide[ACC_W-1:0];
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_hit_max  = (w_cnt_inc == CNT_W'(MAX_LEN));

  // Next-state and datapath update for both states.
  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_cnt_next   = r_cnt;
    w_ovf_next   = r_ovf;
    w_trunc_next = r_trunc;
    unique case (r_state)
      StAccum: begin
        if (w_accept) begin
          w_acc_next = w_acc_add;
          w_cnt_next = w_cnt_inc;
          w_ovf_next = r_ovf | w_sat;
          if (bus.prod_last || w_hit_max) begin
            w_state_next = StDone;
            // A last flag on the length-limit beat is a normal end, not truncation.
            w_trunc_next = ~bus.prod_last;
          end
        end
      end
      StDone: begin
        if (bus.sum_ready) begin
          w_state_next = StAccum;
          w_acc_next   = '0;
          w_cnt_next   = '0;
          w_ovf_next   = 1'b0;
          w_trunc_next = 1'b0;
        end
      end
      default: w_state_next = StAccum;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StAccum;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Accumulator, element count and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_trunc <= 1'b0;
    end else begin
      r_acc   <= w_acc_next;
      r_cnt   <= w_cnt_next;
      r_ovf   <= w_ovf_next;
      r_trunc <= w_trunc_next;
    end
  end

  assign bus.sum       = r_acc;
  assign bus.count     = r_cnt;
  assign bus.overflow  = r_ovf;
  assign bus.truncated = r_trunc;
  assign bus.sum_valid = (r_state == StDone);

endmodule
